// File: rtl/ifu_fetch_ctrl_if.sv
// Fetch-controller bundle: imem request/response, redirect/stall control and the IF/ID load path.
interface ifu_fetch_ctrl_if #(
    parameter int unsigned PC_WIDTH    = 32,
    parameter int unsigned INSTR_WIDTH = 32
);
    logic                   imem_req_valid;
    logic                   imem_req_ready;
    logic [PC_WIDTH-1:0]    imem_req_addr;
    logic                   imem_rsp_valid;
    logic [INSTR_WIDTH-1:0] imem_rsp_data;
    logic                   redirect_valid;
    logic [PC_WIDTH-1:0]    redirect_pc;
    logic                   stall;
    logic [PC_WIDTH-1:0]    fetch_pc;
    logic [INSTR_WIDTH-1:0] fetch_instr;
    logic [PC_WIDTH-1:0]    fetch_pc_4;
    logic                   if_id_reg_enable;
    logic                   bpu_clear_ctrl;

    // Fetch sequencer side
    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  redirect_valid, redirect_pc, stall,
        output fetch_pc, fetch_instr, fetch_pc_4, if_id_reg_enable, bpu_clear_ctrl
    );

    // Memory / pipeline side
    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output redirect_valid, redirect_pc, stall,
        input  fetch_pc, fetch_instr, fetch_pc_4, if_id_reg_enable, bpu_clear_ctrl
    );
endinterface

// File: rtl/ifu_fetch_ctrl.sv
// Instruction-fetch sequencer: one outstanding imem request, hold buffer for stalls,
// drain of wrong-path responses after redirect.
module ifu_fetch_ctrl #(
    parameter int unsigned         PC_WIDTH    = 32,
    parameter int unsigned         INSTR_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = PC_WIDTH'(32'h8000_0000)
) (
    input  logic              clk,
    input  logic              rst,
    ifu_fetch_ctrl_if.master  fetch_if
);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2,
        S_DRAIN = 2'd3
    } state_e;

    state_e                 state_q, state_d;
    logic [PC_WIDTH-1:0]    pc_q, pc_d;
    logic [INSTR_WIDTH-1:0] hold_q, hold_d;

    logic                   req_valid_c;
    logic                   enable_c;
    logic                   clear_c;
    logic [INSTR_WIDTH-1:0] instr_c;
    logic [PC_WIDTH-1:0]    pc_4_c;

    assign pc_4_c = pc_q + PC_WIDTH'(4);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            hold_q  <= hold_d;
        end
    end

    // Next state and strobes; redirect outranks response and stall in every state
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        hold_d      = hold_q;
        req_valid_c = 1'b0;
        enable_c    = 1'b0;
        clear_c     = fetch_if.redirect_valid;
        instr_c     = fetch_if.imem_rsp_data;

        case (state_q)
            S_REQ: begin
                req_valid_c = 1'b1;
                if (fetch_if.redirect_valid) begin
                    pc_d    = fetch_if.redirect_pc;
                    state_d = fetch_if.imem_req_ready ? S_DRAIN : S_REQ;
                end else if (fetch_if.imem_req_ready) begin
                    state_d = S_WAIT;
                end
            end

            S_WAIT: begin
                if (fetch_if.redirect_valid) begin
                    pc_d    = fetch_if.redirect_pc;
                    state_d = fetch_if.imem_rsp_valid ? S_REQ : S_DRAIN;
                end else if (fetch_if.imem_rsp_valid) begin
                    if (fetch_if.stall) begin
                        hold_d  = fetch_if.imem_rsp_data;
                        state_d = S_HOLD;
                    end else begin
                        enable_c = 1'b1;
                        pc_d     = pc_4_c;
                        state_d  = S_REQ;
                    end
                end
            end

            S_HOLD: begin
                instr_c = hold_q;
                if (fetch_if.redirect_valid) begin
                    pc_d    = fetch_if.redirect_pc;
                    state_d = S_REQ;
                end else if (!fetch_if.stall) begin
                    enable_c = 1'b1;
                    pc_d     = pc_4_c;
                    state_d  = S_REQ;
                end
            end

            S_DRAIN: begin
                if (fetch_if.redirect_valid) begin
                    pc_d = fetch_if.redirect_pc;
                end
                // The stale word retires the outstanding request even if a redirect lands with it
                if (fetch_if.imem_rsp_valid) begin
                    state_d = S_REQ;
                end
            end

            default: begin
                state_d = S_REQ;
            end
        endcase
    end

    // Everything is forced low while reset is held
    assign fetch_if.imem_req_valid   = ~rst & req_valid_c;
    assign fetch_if.imem_req_addr    = rst ? '0 : pc_q;
    assign fetch_if.fetch_pc         = rst ? '0 : pc_q;
    assign fetch_if.fetch_pc_4       = rst ? '0 : pc_4_c;
    assign fetch_if.fetch_instr      = rst ? '0 : instr_c;
    assign fetch_if.if_id_reg_enable = ~rst & enable_c;
    assign fetch_if.bpu_clear_ctrl   = ~rst & clear_c;

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Directed scenarios followed by a randomized run against a transaction-level fetch model.
module tb_ifu_fetch_ctrl;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    ifu_fetch_ctrl_if #(.PC_WIDTH(32), .INSTR_WIDTH(32)) bus ();

    ifu_fetch_ctrl #(
        .PC_WIDTH   (32),
        .INSTR_WIDTH(32),
        .RESET_PC   (32'h8000_0000)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .fetch_if(bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    logic [31:0] exp_pc;
    logic [31:0] pend_addr;
    logic [31:0] old_pc;
    bit          pend;
    bit          live;
    bit          held;
    bit          exp_en;
    bit          exp_rv;
    bit          rsp;
    bit          redir;
    bit          st;
    int          cnt;
    int          delivered;

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.stall          = 1'b0;

        // Reset: everything low
        repeat (2) @(posedge clk);
        settle();
        chk("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
        chk("rst_req_addr", bus.imem_req_addr, 32'd0);
        chk("rst_enable", 32'(bus.if_id_reg_enable), 32'd0);
        chk("rst_clear", 32'(bus.bpu_clear_ctrl), 32'd0);
        chk("rst_fetch_pc_4", bus.fetch_pc_4, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Zero-wait memory: one instruction every two cycles
        for (int i = 0; i < 3; i++) begin
            bus.imem_req_ready = 1'b1;
            bus.imem_rsp_valid = 1'b0;
            settle();
            chk("seq_req_valid", 32'(bus.imem_req_valid), 32'd1);
            chk("seq_req_addr", bus.imem_req_addr, 32'h8000_0000 + 32'(4 * i));
            chk("seq_idle_enable", 32'(bus.if_id_reg_enable), 32'd0);
            adv();
            bus.imem_req_ready = 1'b0;
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = 32'h0000_1000 + 32'(i);
            settle();
            chk("seq_enable", 32'(bus.if_id_reg_enable), 32'd1);
            chk("seq_instr", bus.fetch_instr, 32'h0000_1000 + 32'(i));
            chk("seq_pc", bus.fetch_pc, 32'h8000_0000 + 32'(4 * i));
            chk("seq_pc_4", bus.fetch_pc_4, 32'h8000_0004 + 32'(4 * i));
            chk("seq_no_req", 32'(bus.imem_req_valid), 32'd0);
            adv();
        end
        bus.imem_rsp_valid = 1'b0;

        // Response under a 3-cycle stall is held, then delivered
        bus.imem_req_ready = 1'b1;
        settle();
        chk("hold_req_addr", bus.imem_req_addr, 32'h8000_000C);
        adv();
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 32'h0000_0013;
        bus.stall          = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("hold_no_enable", 32'(bus.if_id_reg_enable), 32'd0);
            chk("hold_no_req", 32'(bus.imem_req_valid), 32'd0);
            adv();
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = 32'hBAD0_BAD0;
        end
        bus.stall = 1'b0;
        settle();
        chk("hold_enable", 32'(bus.if_id_reg_enable), 32'd1);
        chk("hold_instr", bus.fetch_instr, 32'h0000_0013);
        chk("hold_pc", bus.fetch_pc, 32'h8000_000C);
        adv();

        // Redirect in WAIT, stale response two cycles later is dropped
        bus.imem_req_ready = 1'b1;
        settle();
        chk("drain_req_addr", bus.imem_req_addr, 32'h8000_0010);
        adv();
        bus.imem_req_ready = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h8000_0100;
        settle();
        chk("drain_clear", 32'(bus.bpu_clear_ctrl), 32'd1);
        chk("drain_clear_no_enable", 32'(bus.if_id_reg_enable), 32'd0);
        adv();
        bus.redirect_valid = 1'b0;
        settle();
        chk("drain_clear_once", 32'(bus.bpu_clear_ctrl), 32'd0);
        chk("drain_no_req", 32'(bus.imem_req_valid), 32'd0);
        adv();
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 32'hDEAD_BEEF;
        settle();
        chk("drain_discard", 32'(bus.if_id_reg_enable), 32'd0);
        chk("drain_discard_no_req", 32'(bus.imem_req_valid), 32'd0);
        adv();
        bus.imem_rsp_valid = 1'b0;
        bus.imem_req_ready = 1'b1;
        settle();
        chk("drain_next_valid", 32'(bus.imem_req_valid), 32'd1);
        chk("drain_next_addr", bus.imem_req_addr, 32'h8000_0100);
        adv();

        // Redirect coincident with response and stall
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 32'h1111_2222;
        bus.stall          = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h8000_0200;
        settle();
        chk("coin_clear", 32'(bus.bpu_clear_ctrl), 32'd1);
        chk("coin_enable", 32'(bus.if_id_reg_enable), 32'd0);
        adv();
        bus.imem_rsp_valid = 1'b0;
        bus.stall          = 1'b0;
        bus.redirect_valid = 1'b0;
        settle();
        chk("coin_next_valid", 32'(bus.imem_req_valid), 32'd1);
        chk("coin_next_addr", bus.imem_req_addr, 32'h8000_0200);

        // Wrap at the top of the address space
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFFC;
        adv();
        bus.redirect_valid = 1'b0;
        bus.imem_req_ready = 1'b1;
        settle();
        chk("wrap_req_addr", bus.imem_req_addr, 32'hFFFF_FFFC);
        adv();
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 32'h0000_0033;
        settle();
        chk("wrap_enable", 32'(bus.if_id_reg_enable), 32'd1);
        chk("wrap_pc_4", bus.fetch_pc_4, 32'h0000_0000);
        adv();
        bus.imem_rsp_valid = 1'b0;
        bus.imem_req_ready = 1'b1;
        settle();
        chk("wrap_next_addr", bus.imem_req_addr, 32'h0000_0000);
        adv();

        // Async reset mid-WAIT, then a late response
        bus.imem_req_ready = 1'b0;
        settle();
        chk("arst_pre_pc_4", bus.fetch_pc_4, 32'h0000_0004);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_pc_4", bus.fetch_pc_4, 32'd0);
        chk("arst_req_valid", 32'(bus.imem_req_valid), 32'd0);
        chk("arst_addr", bus.imem_req_addr, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 32'hBAD1_BAD1;
        settle();
        chk("stray_enable", 32'(bus.if_id_reg_enable), 32'd0);
        chk("stray_req_addr", bus.imem_req_addr, 32'h8000_0000);
        adv();
        bus.imem_rsp_valid = 1'b0;
        bus.imem_req_ready = 1'b1;
        settle();
        chk("stray_pc_kept", bus.imem_req_addr, 32'h8000_0000);
        adv();
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 32'h0000_0077;
        settle();
        chk("restart_enable", 32'(bus.if_id_reg_enable), 32'd1);
        chk("restart_pc", bus.fetch_pc, 32'h8000_0000);
        adv();
        bus.imem_rsp_valid = 1'b0;

        // Randomized traffic against the fetch model
        exp_pc    = 32'h8000_0004;
        pend      = 1'b0;
        live      = 1'b0;
        held      = 1'b0;
        cnt       = 0;
        pend_addr = '0;
        delivered = 0;
        for (int c = 0; c < 3000; c++) begin
            bus.stall          = ($urandom_range(0, 9) < 3);
            bus.redirect_valid = ($urandom_range(0, 15) == 0);
            bus.redirect_pc    = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8
                                                             : ($urandom() & 32'hFFFF_FFFC);
            bus.imem_req_ready = ($urandom_range(0, 9) < 7);
            bus.imem_rsp_valid = pend && (cnt == 0);
            bus.imem_rsp_data  = bus.imem_rsp_valid ? mem_word(pend_addr) : $urandom();
            settle();
            rsp    = bus.imem_rsp_valid;
            redir  = bus.redirect_valid;
            st     = bus.stall;
            exp_en = !redir && !st && (held || (rsp && live));
            exp_rv = !pend && !held;
            chk("rnd_enable", 32'(bus.if_id_reg_enable), 32'(exp_en));
            chk("rnd_clear", 32'(bus.bpu_clear_ctrl), 32'(redir));
            chk("rnd_req_valid", 32'(bus.imem_req_valid), 32'(exp_rv));
            if (exp_rv) chk("rnd_req_addr", bus.imem_req_addr, exp_pc);
            if (exp_en) begin
                chk("rnd_instr", bus.fetch_instr, mem_word(exp_pc));
                chk("rnd_pc", bus.fetch_pc, exp_pc);
                chk("rnd_pc_4", bus.fetch_pc_4, exp_pc + 32'd4);
                delivered++;
            end
            old_pc = exp_pc;
            if (redir) begin
                held   = 1'b0;
                live   = 1'b0;
                exp_pc = bus.redirect_pc;
            end else begin
                if (rsp && live && st) held = 1'b1;
                if (exp_en) begin
                    held   = 1'b0;
                    exp_pc = exp_pc + 32'd4;
                end
            end
            if (rsp) begin
                pend = 1'b0;
                live = 1'b0;
            end else if (pend) begin
                cnt--;
            end
            if (exp_rv && bus.imem_req_ready) begin
                pend      = 1'b1;
                live      = !redir;
                cnt       = $urandom_range(0, 2);
                pend_addr = old_pc;
            end
            adv();
        end
        chk("rnd_progress", 32'(delivered >= 100), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
